// File: rtl/rvv_backend_rob_gen.sv
// Parametrised reorder buffer for the RVV backend.
//
// Dispatch pushes up to NUM_DP uops per cycle in program order. NUM_WB
// writeback ports deliver results out of order. Up to NUM_RT uops retire per
// cycle in program order. Retiring a trapped uop empties the whole buffer.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   dp_valid/info/ready   dispatch push slots; dp_index = entry of slot 0
//   wb_valid/entry/data/wvalid/sat   writeback ports (always accepted)
//   trap_valid/entry/ready           trap report (always accepted)
//   rt_valid/ready/info/data/wvalid/sat/trap   retire slots, entry rptr+i
//   ord_valid/done/wvalid/info/data  program-order view, entry rptr+k
//   count                 occupied entries (DEPTH means full)
//   flush_out             one-cycle pulse after a trapped uop retires
//   wb_err                one-cycle pulse on a writeback collision or a
//                         writeback to an unoccupied entry
module rvv_backend_rob_gen #(
  parameter int  DEPTH  = 8,
  parameter int  NUM_DP = 2,
  parameter int  NUM_RT = 4,
  parameter int  NUM_WB = 9,
  parameter int  DATA_W = 128,
  parameter int  INFO_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_DP-1:0]        dp_valid,
  input  logic [NUM_DP*INFO_W-1:0] dp_info,
  output logic [NUM_DP-1:0]        dp_ready,
  output logic [AW-1:0]            dp_index,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*AW-1:0]     wb_entry,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_wvalid,
  input  logic [NUM_WB-1:0]        wb_sat,
  input  logic                     trap_valid,
  input  logic [AW-1:0]            trap_entry,
  output logic                     trap_ready,
  output logic [NUM_RT-1:0]        rt_valid,
  input  logic [NUM_RT-1:0]        rt_ready,
  output logic [NUM_RT*INFO_W-1:0] rt_info,
  output logic [NUM_RT*DATA_W-1:0] rt_data,
  output logic [NUM_RT-1:0]        rt_wvalid,
  output logic [NUM_RT-1:0]        rt_sat,
  output logic [NUM_RT-1:0]        rt_trap,
  output logic [DEPTH-1:0]         ord_valid,
  output logic [DEPTH-1:0]         ord_done,
  output logic [DEPTH-1:0]         ord_wvalid,
  output logic [DEPTH*INFO_W-1:0]  ord_info,
  output logic [DEPTH*DATA_W-1:0]  ord_data,
  output logic [AW:0]              count,
  output logic                     flush_out,
  output logic                     wb_err
);

  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic [DEPTH-1:0]  valid_q, done_q, trap_q, wvalid_q, sat_q;
  logic [INFO_W-1:0] info_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              flush_q, wb_err_q;

  logic              trap_at_head, flush, wb_err_d;
  logic [AW:0]       free_n, push_n, pop_n;
  logic [NUM_DP-1:0] push_acc;
  logic [NUM_RT-1:0] pop_acc;
  logic [DEPTH-1:0]  valid_d, done_d, trap_d, wb_hit;
  logic [AW-1:0]     wb_e;

  assign count      = cnt;
  assign dp_index   = wptr;
  assign trap_ready = 1'b1;
  assign flush_out  = flush_q;
  assign wb_err     = wb_err_q;

  // Program-order view of every entry, rotated so index 0 is the head.
  always_comb begin
    ord_valid = '0;
    ord_done = '0;
    ord_wvalid = '0;
    ord_info = '0;
    ord_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ord_valid[k]  = valid_q[rptr + AW'(k)];
      ord_done[k]   = done_q[rptr + AW'(k)];
      ord_wvalid[k] = done_q[rptr + AW'(k)] & wvalid_q[rptr + AW'(k)];
      ord_info[k*INFO_W +: INFO_W] = info_q[rptr + AW'(k)];
      ord_data[k*DATA_W +: DATA_W] = data_q[rptr + AW'(k)];
    end
  end

  // Retire window: a slot is offered only if every older slot is offered
  // and untrapped, so a trapped uop is always the youngest one offered.
  always_comb begin
    logic chain;
    chain = 1'b1;
    trap_at_head = 1'b0;
    rt_valid = '0;
    rt_trap = '0;
    rt_wvalid = '0;
    rt_sat = '0;
    rt_info = '0;
    rt_data = '0;
    for (int i = 0; i < NUM_RT; i++) begin
      rt_valid[i]  = chain & valid_q[rptr + AW'(i)] & done_q[rptr + AW'(i)];
      rt_trap[i]   = trap_q[rptr + AW'(i)];
      rt_wvalid[i] = wvalid_q[rptr + AW'(i)];
      rt_sat[i]    = sat_q[rptr + AW'(i)];
      rt_info[i*INFO_W +: INFO_W] = info_q[rptr + AW'(i)];
      rt_data[i*DATA_W +: DATA_W] = data_q[rptr + AW'(i)];
      chain = rt_valid[i] & ~trap_q[rptr + AW'(i)];
      trap_at_head = trap_at_head | (rt_valid[i] & trap_q[rptr + AW'(i)]);
    end
  end

  // Push and pop counts. Free space uses the pre-pop count, so entries
  // retired this cycle cannot be reused until the next one.
  always_comb begin
    logic chain;
    free_n = (AW+1)'(DEPTH) - cnt;
    dp_ready = '0;
    push_acc = '0;
    push_n = '0;
    chain = 1'b1;
    for (int i = 0; i < NUM_DP; i++) begin
      dp_ready[i] = (free_n > (AW+1)'(i)) && !trap_at_head;
      chain = chain & dp_valid[i] & dp_ready[i];
      push_acc[i] = chain;
      push_n = push_n + (AW+1)'(chain);
    end
    pop_acc = '0;
    pop_n = '0;
    flush = 1'b0;
    chain = 1'b1;
    for (int i = 0; i < NUM_RT; i++) begin
      chain = chain & rt_valid[i] & rt_ready[i];
      pop_acc[i] = chain;
      pop_n = pop_n + (AW+1)'(chain);
      flush = flush | (chain & rt_trap[i]);
    end
  end

  // Entry flag updates: writeback and trap marks first, then pops clear the
  // head, then pushes claim free slots (never overlapping the pops).
  always_comb begin
    valid_d = valid_q;
    done_d = done_q;
    trap_d = trap_q;
    wb_hit = '0;
    wb_err_d = 1'b0;
    wb_e = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p]) begin
        wb_e = wb_entry[p*AW +: AW];
        if (wb_hit[wb_e] || !valid_q[wb_e]) wb_err_d = 1'b1;
        wb_hit[wb_e] = 1'b1;
        if (valid_q[wb_e]) done_d[wb_e] = 1'b1;
      end
    end
    if (trap_valid && valid_q[trap_entry]) trap_d[trap_entry] = 1'b1;
    for (int i = 0; i < NUM_RT; i++) begin
      if (pop_acc[i]) begin
        valid_d[rptr + AW'(i)] = 1'b0;
        done_d[rptr + AW'(i)]  = 1'b0;
        trap_d[rptr + AW'(i)]  = 1'b0;
      end
    end
    for (int i = 0; i < NUM_DP; i++) begin
      if (push_acc[i]) begin
        valid_d[wptr + AW'(i)] = 1'b1;
        done_d[wptr + AW'(i)]  = 1'b0;
        trap_d[wptr + AW'(i)]  = 1'b0;
      end
    end
    if (flush) begin
      valid_d = '0;
      done_d = '0;
      trap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      trap_q   <= '0;
      flush_q  <= 1'b0;
      wb_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      trap_q   <= trap_d;
      flush_q  <= flush;
      wb_err_q <= wb_err_d;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        wptr <= wptr + push_n[AW-1:0];
        rptr <= rptr + pop_n[AW-1:0];
        cnt  <= cnt + push_n - pop_n;
      end
    end
  end

  // Payload storage; later ports overwrite earlier ones on a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DP; i++) begin
      if (push_acc[i]) info_q[wptr + AW'(i)] <= dp_info[i*INFO_W +: INFO_W];
    end
    for (int p = 0; p < NUM_WB; p++) begin
      if (!flush && wb_valid[p] && valid_q[wb_entry[p*AW +: AW]]) begin
        data_q[wb_entry[p*AW +: AW]]   <= wb_data[p*DATA_W +: DATA_W];
        wvalid_q[wb_entry[p*AW +: AW]] <= wb_wvalid[p];
        sat_q[wb_entry[p*AW +: AW]]    <= wb_sat[p];
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_rob_gen.sv
// Bench for rvv_backend_rob_gen: a program-order queue model of the buffer,
// directed scenarios followed by randomized traffic with a mid-run reset.
module tb_rvv_backend_rob_gen;
  localparam int DEPTH = 8, NUM_DP = 2, NUM_RT = 4, NUM_WB = 9;
  localparam int DATA_W = 128, INFO_W = 32, AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_DP-1:0]        dp_valid;
  logic [NUM_DP*INFO_W-1:0] dp_info;
  logic [NUM_DP-1:0]        dp_ready;
  logic [AW-1:0]            dp_index;
  logic [NUM_WB-1:0]        wb_valid, wb_wvalid, wb_sat;
  logic [NUM_WB*AW-1:0]     wb_entry;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic                     trap_valid, trap_ready;
  logic [AW-1:0]            trap_entry;
  logic [NUM_RT-1:0]        rt_valid, rt_ready, rt_wvalid, rt_sat, rt_trap;
  logic [NUM_RT*INFO_W-1:0] rt_info;
  logic [NUM_RT*DATA_W-1:0] rt_data;
  logic [DEPTH-1:0]         ord_valid, ord_done, ord_wvalid;
  logic [DEPTH*INFO_W-1:0]  ord_info;
  logic [DEPTH*DATA_W-1:0]  ord_data;
  logic [AW:0]              count;
  logic                     flush_out, wb_err;

  rvv_backend_rob_gen dut (
    .clk(clk), .rst_n(rst_n),
    .dp_valid(dp_valid), .dp_info(dp_info), .dp_ready(dp_ready), .dp_index(dp_index),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_data(wb_data),
    .wb_wvalid(wb_wvalid), .wb_sat(wb_sat),
    .trap_valid(trap_valid), .trap_entry(trap_entry), .trap_ready(trap_ready),
    .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_info(rt_info), .rt_data(rt_data),
    .rt_wvalid(rt_wvalid), .rt_sat(rt_sat), .rt_trap(rt_trap),
    .ord_valid(ord_valid), .ord_done(ord_done), .ord_wvalid(ord_wvalid),
    .ord_info(ord_info), .ord_data(ord_data),
    .count(count), .flush_out(flush_out), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INFO_W-1:0] info;
    logic [DATA_W-1:0] data;
    bit done, wv, sat, trap;
  } ent_t;

  ent_t q[$];          // occupied entries, oldest first
  int   m_rptr;        // entry number of q[0]
  bit   e_flush, e_err;
  int   n_vec = 0, n_bad = 0;
  logic [DATA_W-1:0] d2, d7;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_RT-1:0] m_rtv();
    logic [NUM_RT-1:0] r = '0;
    bit ok = 1;
    for (int i = 0; i < NUM_RT; i++) begin
      if (ok && i < q.size() && q[i].done) r[i] = 1'b1;
      else ok = 0;
      if (ok && q[i].trap) ok = 0;
    end
    return r;
  endfunction

  function automatic bit m_trap_head();
    logic [NUM_RT-1:0] r = m_rtv();
    for (int i = 0; i < NUM_RT; i++) if (r[i] && q[i].trap) return 1;
    return 0;
  endfunction

  task automatic idle();
    dp_valid = '0; dp_info = '0; wb_valid = '0; wb_entry = '0; wb_data = '0;
    wb_wvalid = '0; wb_sat = '0; trap_valid = 1'b0; trap_entry = '0; rt_ready = '0;
  endtask

  task automatic check_all();
    int n = q.size();
    logic [NUM_RT-1:0] rv = m_rtv();
    bit th = m_trap_head();
    logic [NUM_DP-1:0] er = '0;
    logic [DEPTH-1:0] ev = '0, ed = '0, ew = '0;
    for (int i = 0; i < NUM_DP; i++) er[i] = (DEPTH - n > i) && !th;
    for (int k = 0; k < n; k++) begin
      ev[k] = 1'b1; ed[k] = q[k].done; ew[k] = q[k].done & q[k].wv;
    end
    check_val("count", count, n);
    check_val("dp_index", dp_index, (m_rptr + n) % DEPTH);
    check_val("dp_ready", dp_ready, er);
    check_val("rt_valid", rt_valid, rv);
    check_val("ord_valid", ord_valid, ev);
    check_val("ord_done", ord_done, ed);
    check_val("ord_wvalid", ord_wvalid, ew);
    check_val("flush_out", flush_out, e_flush);
    check_val("wb_err", wb_err, e_err);
    check_val("trap_ready", trap_ready, 1);
    for (int k = 0; k < n; k++) begin
      check_val($sformatf("ord_info%0d", k), ord_info[k*INFO_W +: INFO_W], q[k].info);
      if (q[k].done) check_val($sformatf("ord_data%0d", k), ord_data[k*DATA_W +: DATA_W], q[k].data);
    end
    for (int i = 0; i < NUM_RT; i++) begin
      if (rv[i]) begin
        check_val($sformatf("rt_info%0d", i), rt_info[i*INFO_W +: INFO_W], q[i].info);
        check_val($sformatf("rt_data%0d", i), rt_data[i*DATA_W +: DATA_W], q[i].data);
        check_val($sformatf("rt_flags%0d", i), {rt_wvalid[i], rt_sat[i], rt_trap[i]},
                  {q[i].wv, q[i].sat, q[i].trap});
      end
    end
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // let the DUT take the same edge and compare.
  task automatic tick();
    int n = q.size();
    if (!rst_n) begin
      q.delete(); m_rptr = 0; e_flush = 0; e_err = 0;
    end else begin
      logic [NUM_RT-1:0] rv = m_rtv();
      bit th = m_trap_head();
      bit hit[DEPTH];
      int npush = 0, npop = 0, e, pos;
      bit fl = 0, err = 0;
      for (int i = 0; i < NUM_DP; i++)
        if (npush == i && dp_valid[i] && (DEPTH - n > i) && !th) npush++;
      for (int i = 0; i < NUM_RT; i++)
        if (npop == i && rv[i] && rt_ready[i]) begin npop++; if (q[i].trap) fl = 1; end
      for (int i = 0; i < DEPTH; i++) hit[i] = 0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p]) begin
          e = int'(wb_entry[p*AW +: AW]);
          pos = (e - m_rptr + DEPTH) % DEPTH;
          if (hit[e] || pos >= n) err = 1;
          hit[e] = 1;
          if (pos < n) begin
            ent_t t = q[pos];
            t.done = 1; t.data = wb_data[p*DATA_W +: DATA_W];
            t.wv = wb_wvalid[p]; t.sat = wb_sat[p];
            q[pos] = t;
          end
        end
      end
      if (trap_valid) begin
        pos = (int'(trap_entry) - m_rptr + DEPTH) % DEPTH;
        if (pos < n) begin ent_t t = q[pos]; t.trap = 1; q[pos] = t; end
      end
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      for (int i = 0; i < npush; i++) begin
        ent_t t;
        t.info = dp_info[i*INFO_W +: INFO_W]; t.data = '0;
        t.done = 0; t.wv = 0; t.sat = 0; t.trap = 0;
        q.push_back(t);
      end
      if (fl) begin q.delete(); m_rptr = 0; end
      else m_rptr = (m_rptr + npop) % DEPTH;
      e_flush = fl; e_err = err;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic wb1(input int port, input int entry, input logic [DATA_W-1:0] d);
    wb_valid[port] = 1'b1;
    wb_entry[port*AW +: AW] = AW'(entry);
    wb_data[port*DATA_W +: DATA_W] = d;
    wb_wvalid[port] = 1'b1;
    wb_sat[port] = d[0];
  endtask

  task automatic rand_inputs();
    int n = q.size();
    int e;
    idle();
    dp_valid = NUM_DP'($urandom);
    for (int i = 0; i < NUM_DP; i++) dp_info[i*INFO_W +: INFO_W] = $urandom;
    for (int i = 0; i < NUM_RT; i++) rt_ready[i] = ($urandom_range(0, 3) != 0);
    for (int p = 0; p < NUM_WB; p++) begin
      wb_valid[p] = ($urandom_range(0, 4) == 0);
      if (n > 0 && $urandom_range(0, 9) != 0) e = (m_rptr + $urandom_range(0, n - 1)) % DEPTH;
      else e = $urandom_range(0, DEPTH - 1);
      wb_entry[p*AW +: AW] = AW'(e);
      wb_data[p*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
      wb_wvalid[p] = $urandom_range(0, 1);
      wb_sat[p] = $urandom_range(0, 1);
    end
    trap_valid = ($urandom_range(0, 24) == 0);
    if (n > 0) e = (m_rptr + $urandom_range(0, n - 1)) % DEPTH;
    else e = $urandom_range(0, DEPTH - 1);
    trap_entry = AW'(e);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check_val("rst_ready", dp_ready, 2'b11);
    rst_n = 1'b1;

    // Fill the buffer two at a time.
    for (int c = 0; c < 4; c++) begin
      idle(); dp_valid = 2'b11;
      dp_info = {32'hA000_0000 + 2*c + 1, 32'hA000_0000 + 2*c};
      tick();
    end
    check_val("full_count", count, 8);
    check_val("full_ready", dp_ready, 2'b00);

    // Out-of-order results to entries 3,1,0,2.
    idle(); wb1(0, 3, 128'h33); tick();
    idle(); wb1(0, 1, 128'h11); tick();
    idle(); wb1(0, 0, 128'h10); tick();
    check_val("rtv_01", rt_valid, 4'b0011);
    idle(); wb1(0, 2, 128'h22); tick();
    check_val("rtv_all", rt_valid, 4'b1111);

    // Ports 2 and 7 collide on entry 3: port 7 wins.
    d2 = {4{32'h2222_2222}}; d7 = {4{32'h7777_7777}};
    idle(); wb1(2, 3, d2); wb1(7, 3, d7); tick();
    check_val("coll_data", ord_data[3*DATA_W +: DATA_W], d7);
    check_val("coll_err", wb_err, 1);

    idle(); rt_ready = 4'b1111; tick();
    check_val("pop_count", count, 4);
    check_val("coll_err_clr", wb_err, 0);

    // Write to an empty entry.
    idle(); wb1(0, 0, 128'h5); tick();
    check_val("empty_err", wb_err, 1);
    check_val("empty_done", ord_done, 0);

    // Trap on entry 5 with entries 4-6 done, then retire both offered slots.
    idle(); wb1(0, 4, 128'h44); wb1(1, 5, 128'h55); wb1(2, 6, 128'h66);
    trap_valid = 1'b1; trap_entry = 3'd5; tick();
    check_val("trap_rtv", rt_valid, 4'b0011);
    check_val("trap_ready_dp", dp_ready, 2'b00);
    idle(); rt_ready = 4'b1111; tick();
    check_val("flush_pulse", flush_out, 1);
    check_val("flush_count", count, 0);
    check_val("flush_index", dp_index, 0);
    idle(); tick();
    check_val("flush_end", flush_out, 0);
    check_val("flush_ready", dp_ready, 2'b11);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin rand_inputs(); tick(); end

    // Reset in the middle of traffic, preferably at count 5.
    for (int c = 0; c < 400 && q.size() != 5; c++) begin rand_inputs(); tick(); end
    rand_inputs(); rst_n = 1'b0; tick();
    check_val("mid_rst_count", count, 0);
    check_val("mid_rst_rtv", rt_valid, 0);
    check_val("mid_rst_flush", flush_out, 0);
    rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin rand_inputs(); tick(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
